candidate_writer: RTL

Upstream feeder for the detection result store. Collects per-window classification outcomes from the multi-scale Haar cascade: the window origin plus one pass bit per resize level. Windows with at least one passing scale go into a small internal queue. Each queued candidate is replayed into the result store as a 3-cycle write burst, and the block then waits for the store's write-complete pulse before starting the next burst.

---
 rtl/candidate_writer_if.sv | 40 ++++
 rtl/candidate_writer.sv | 171 +++++++++++++++++
 2 files changed

// File: rtl/candidate_writer_if.sv
// Purpose : bundles the window-result input and result-store write bus of
//           candidate_writer into one interface.
// Ports   : window_valid/ori_x/ori_y/pass  - classifier window result strobe
//           write_in_end                   - result-store burst-complete pulse
//           o_write_in/o_ori_x/o_ori_y/o_candidate - write burst to result store
//           o_busy/o_full/o_accept_count/o_drop_count/o_error - status
// Modports: slave  - seen by candidate_writer
//           master - seen by the driver of the window results / result store
interface candidate_writer_if #(
   parameter int unsigned DATA_WIDTH_12 = 12,
   parameter int unsigned DATA_WIDTH_16 = 16,
   parameter int unsigned NUM_RESIZE    = 5
);
   logic                     window_valid;
   logic [DATA_WIDTH_12-1:0] ori_x;
   logic [DATA_WIDTH_12-1:0] ori_y;
   logic [NUM_RESIZE-1:0]    pass;
   logic                     write_in_end;
   logic                     o_write_in;
   logic [DATA_WIDTH_12-1:0] o_ori_x;
   logic [DATA_WIDTH_12-1:0] o_ori_y;
   logic [NUM_RESIZE-1:0]    o_candidate;
   logic                     o_busy;
   logic                     o_full;
   logic [DATA_WIDTH_16-1:0] o_accept_count;
   logic [DATA_WIDTH_16-1:0] o_drop_count;
   logic                     o_error;

   modport slave (
      input  window_valid, ori_x, ori_y, pass, write_in_end,
      output o_write_in, o_ori_x, o_ori_y, o_candidate,
      output o_busy, o_full, o_accept_count, o_drop_count, o_error
   );

   modport master (
      output window_valid, ori_x, ori_y, pass, write_in_end,
      input  o_write_in, o_ori_x, o_ori_y, o_candidate,
      input  o_busy, o_full, o_accept_count, o_drop_count, o_error
   );
endinterface

// File: rtl/candidate_writer.sv
// Purpose : queues Haar-cascade windows that passed at least one resize level
//           and replays each as a 3-cycle write burst into the result store,
//           waiting for write_in_end (or a timeout) between bursts.
// Ports   : clk   - system clock, rising edge
//           reset - asynchronous, active-high
//           bus   - candidate_writer_if.slave (window input, write burst,
//                   status counters and flags)
module candidate_writer #(
   parameter int unsigned DATA_WIDTH_12 = 12,
   parameter int unsigned DATA_WIDTH_16 = 16,
   parameter int unsigned NUM_RESIZE    = 5,
   parameter int unsigned QUEUE_DEPTH   = 4,
   parameter int unsigned END_TIMEOUT   = 15
) (
   input  logic               clk,
   input  logic               reset,
   candidate_writer_if.slave  bus
);
   localparam int unsigned PTR_W   = (QUEUE_DEPTH > 1) ? $clog2(QUEUE_DEPTH) : 1;
   localparam int unsigned CNT_W   = $clog2(QUEUE_DEPTH + 1);
   localparam int unsigned TMR_MAX = (END_TIMEOUT > 3) ? END_TIMEOUT : 3;
   localparam int unsigned TMR_W   = $clog2(TMR_MAX + 1);

   typedef struct packed {
      logic [DATA_WIDTH_12-1:0] x;
      logic [DATA_WIDTH_12-1:0] y;
      logic [NUM_RESIZE-1:0]    pass;
   } cand_t;

   typedef enum logic [1:0] {
      IDLE     = 2'd0,
      WRITE    = 2'd1,
      WAIT_END = 2'd2
   } state_t;

   state_t                   state_q, state_d;
   logic [TMR_W-1:0]         tmr_q, tmr_d;
   logic                     end_seen_q, end_seen_d;
   logic                     timeout_c;

   cand_t                    queue_q [QUEUE_DEPTH];
   logic [PTR_W-1:0]         head_q, tail_q;
   logic [CNT_W-1:0]         count_q, count_d;
   logic                     full_now_c;
   logic                     hit_c;
   logic                     pop_c, push_c, drop_c;
   cand_t                    entry_c;

   logic                     write_in_q;
   logic [DATA_WIDTH_12-1:0] ori_x_q, ori_y_q;
   logic [NUM_RESIZE-1:0]    candidate_q;
   logic                     busy_q, full_q, error_q;
   logic [DATA_WIDTH_16-1:0] accept_q, drop_q;

   // Queue control: a pop frees a slot for a same-cycle push even when full.
   always_comb begin
      hit_c      = bus.window_valid && (bus.pass != '0);
      full_now_c = (count_q == CNT_W'(QUEUE_DEPTH));
      pop_c      = (state_q == IDLE) && (count_q != '0);
      push_c     = hit_c && (!full_now_c || pop_c);
      drop_c     = hit_c && full_now_c && !pop_c;
      count_d    = count_q + CNT_W'(push_c) - CNT_W'(pop_c);
      entry_c    = '{x: bus.ori_x, y: bus.ori_y, pass: bus.pass};
   end

   // Burst FSM: tmr counts write beats in WRITE and elapsed cycles in WAIT_END.
   always_comb begin
      state_d    = state_q;
      tmr_d      = tmr_q;
      end_seen_d = end_seen_q;
      timeout_c  = 1'b0;
      case (state_q)
         IDLE: begin
            if (pop_c) begin
               state_d    = WRITE;
               tmr_d      = '0;
               end_seen_d = 1'b0;
            end
         end
         WRITE: begin
            // An early completion pulse is remembered for WAIT_END.
            if (bus.write_in_end) end_seen_d = 1'b1;
            if (tmr_q == TMR_W'(2)) begin
               state_d = WAIT_END;
               tmr_d   = '0;
            end else begin
               tmr_d = tmr_q + TMR_W'(1);
            end
         end
         WAIT_END: begin
            if (end_seen_q || bus.write_in_end) begin
               state_d = IDLE;
            end else if (tmr_q == TMR_W'(END_TIMEOUT - 1)) begin
               state_d   = IDLE;
               timeout_c = 1'b1;
            end else begin
               tmr_d = tmr_q + TMR_W'(1);
            end
         end
         default: state_d = IDLE;
      endcase
   end

   // FSM state register.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q    <= IDLE;
         tmr_q      <= '0;
         end_seen_q <= 1'b0;
      end else begin
         state_q    <= state_d;
         tmr_q      <= tmr_d;
         end_seen_q <= end_seen_d;
      end
   end

   // Queue storage; emptiness is carried by the pointers, so no reset needed.
   always_ff @(posedge clk) begin
      if (push_c) queue_q[tail_q] <= entry_c;
   end

   // Queue pointers and occupancy.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         head_q  <= '0;
         tail_q  <= '0;
         count_q <= '0;
      end else begin
         if (pop_c)  head_q <= head_q + PTR_W'(1);
         if (push_c) tail_q <= tail_q + PTR_W'(1);
         count_q <= count_d;
      end
   end

   // Registered outputs and status counters.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         write_in_q  <= 1'b0;
         ori_x_q     <= '0;
         ori_y_q     <= '0;
         candidate_q <= '0;
         busy_q      <= 1'b0;
         full_q      <= 1'b0;
         accept_q    <= '0;
         drop_q      <= '0;
         error_q     <= 1'b0;
      end else begin
         write_in_q <= (state_d == WRITE);
         if (pop_c) begin
            ori_x_q     <= queue_q[head_q].x;
            ori_y_q     <= queue_q[head_q].y;
            candidate_q <= queue_q[head_q].pass;
         end
         busy_q <= (state_d != IDLE) || (count_d != '0);
         full_q <= (count_d == CNT_W'(QUEUE_DEPTH));
         if (push_c) accept_q <= accept_q + DATA_WIDTH_16'(1);
         if (drop_c && (drop_q != '1)) drop_q <= drop_q + DATA_WIDTH_16'(1);
         if (timeout_c) error_q <= 1'b1;
      end
   end

   assign bus.o_write_in     = write_in_q;
   assign bus.o_ori_x        = ori_x_q;
   assign bus.o_ori_y        = ori_y_q;
   assign bus.o_candidate    = candidate_q;
   assign bus.o_busy         = busy_q;
   assign bus.o_full         = full_q;
   assign bus.o_accept_count = accept_q;
   assign bus.o_drop_count   = drop_q;
   assign bus.o_error        = error_q;
endmodule
